// File: rtl/clk_edge_monitor.sv
// clk_edge_monitor
//   Watches an asynchronous derived clock/strobe (mon_in) from the clk domain.
//   mon_in is synchronised, its edges are detected, and the length of each
//   completed high and low level is measured in clk cycles.
//
// Parameters
//   SYNC_STAGES : synchroniser depth on mon_in (2..4)
//   CNT_W       : width of the level-length and edge counters
//   MIN_PULSE   : shortest legal level length; shorter levels set glitch
//
// Ports
//   clk        in   sampling clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   mon_in     in   monitored signal, asynchronous to clk
//   en         in   monitor enable
//   clear      in   synchronous clear of counters and sticky flags
//   pos_pulse  out  one-cycle pulse per detected rising edge
//   neg_pulse  out  one-cycle pulse per detected falling edge
//   high_len   out  last completed high-level length
//   low_len    out  last completed low-level length
//   len_valid  out  one-cycle strobe when high_len or low_len updates
//   edge_cnt   out  detected edges since clear, saturating
//   glitch     out  sticky: a measured level was shorter than MIN_PULSE
//   len_sat    out  sticky: a level counter saturated
module clk_edge_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MIN_PULSE   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_in,
  input  logic             en,
  input  logic             clear,
  output logic             pos_pulse,
  output logic             neg_pulse,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic             len_valid,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             glitch,
  output logic             len_sat
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_PULSE);

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic [CNT_W-1:0]       lvl_cnt;

  logic sync_lvl;
  logic edge_det;
  logic rise;
  logic fall;
  logic active;

  // Synchroniser and history run independently of en so that the history
  // always tracks the current level; re-enabling never sees a stale edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], mon_in};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign sync_lvl = sync[SYNC_STAGES-1];
  assign edge_det = sync_lvl ^ hist;
  assign rise     = edge_det & sync_lvl;
  assign fall     = edge_det & ~sync_lvl;
  // Edges only count when enabled, not clearing, and past IDLE.
  assign active   = en & ~clear & (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = en ? WAIT_FIRST : IDLE;
    end else if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:       state_nxt = WAIT_FIRST;
        WAIT_FIRST: begin
          if (rise)      state_nxt = HIGH;
          else if (fall) state_nxt = LOW;
        end
        HIGH:       if (edge_det) state_nxt = LOW;
        LOW:        if (edge_det) state_nxt = HIGH;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_pulse <= 1'b0;
      neg_pulse <= 1'b0;
      len_valid <= 1'b0;
      high_len  <= '0;
      low_len   <= '0;
      edge_cnt  <= '0;
      glitch    <= 1'b0;
      len_sat   <= 1'b0;
      lvl_cnt   <= '0;
    end else begin
      pos_pulse <= active & rise;
      neg_pulse <= active & fall;
      len_valid <= 1'b0;
      if (clear) begin
        high_len <= '0;
        low_len  <= '0;
        edge_cnt <= '0;
        glitch   <= 1'b0;
        len_sat  <= 1'b0;
        lvl_cnt  <= '0;
      end else if (active) begin
        if (edge_det) begin
          if (edge_cnt != '1) edge_cnt <= edge_cnt + ONE;
          lvl_cnt <= ONE;
          if (state == HIGH || state == LOW) begin
            len_valid <= 1'b1;
            if (lvl_cnt < MIN_LEN) glitch <= 1'b1;
            if (state == HIGH) high_len <= lvl_cnt;
            else               low_len  <= lvl_cnt;
          end
        end else if (state == HIGH || state == LOW) begin
          // Hold at all-ones; flag when the level outlasts the counter.
          if (lvl_cnt == '1) len_sat <= 1'b1;
          else               lvl_cnt <= lvl_cnt + ONE;
        end
      end
    end
  end

endmodule
